// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
// Build option: define IRQ_RR_EN for round-robin source selection;
// leave it undefined for fixed priority (lowest index wins).
package irq_pkg;

   // Request handshake states
   typedef enum logic [1:0] {
      IRQ_IDLE = 2'd0,
      IRQ_REQ  = 2'd1,
      IRQ_SVC  = 2'd2
   } irq_state_t;

   localparam int IRQ_NUM_SRC_DEF = 4;

   // Well-known source positions on the interrupt vector
   localparam int IRQ_SRC_DMA = 0;
   localparam int IRQ_SRC_WDT = 1;

endpackage : irq_pkg

// File: rtl/irq_prio_sel.sv
// Combinational source selector: picks one index from the eligible vector.
// Build option IRQ_RR_EN: round-robin search starting after i_last_grant.
// Default build: fixed priority, lowest set index wins.
module irq_prio_sel
   import irq_pkg::*;
#(
   parameter int NUM_SRC = IRQ_NUM_SRC_DEF,
   parameter int ID_W    = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] i_eligible,
`ifdef IRQ_RR_EN
   input  logic [ID_W-1:0]    i_last_grant,
`endif
   output logic               o_valid,
   output logic [ID_W-1:0]    o_sel_id
);

`ifdef IRQ_RR_EN
   logic            w_hi_valid;
   logic [ID_W-1:0] w_hi_id;
   logic            w_lo_valid;
   logic [ID_W-1:0] w_lo_id;

   // Two descending scans: indices above the last grant first, then the
   // wrapped range from zero up to and including the last grant.
   always_comb begin
      w_hi_valid = 1'b0;
      w_hi_id    = '0;
      w_lo_valid = 1'b0;
      w_lo_id    = '0;
      for (int j = NUM_SRC - 1; j >= 0; j--) begin
         if (i_eligible[j] && (j > int'(i_last_grant))) begin
            w_hi_valid = 1'b1;
            w_hi_id    = ID_W'(j);
         end
         if (i_eligible[j] && (j <= int'(i_last_grant))) begin
            w_lo_valid = 1'b1;
            w_lo_id    = ID_W'(j);
         end
      end
      o_valid  = w_hi_valid | w_lo_valid;
      o_sel_id = w_hi_valid ? w_hi_id : w_lo_id;
   end
`else
   // Descending scan so the lowest eligible index is the last one written
   always_comb begin
      o_valid  = 1'b0;
      o_sel_id = '0;
      for (int j = NUM_SRC - 1; j >= 0; j--) begin
         if (i_eligible[j]) begin
            o_valid  = 1'b1;
            o_sel_id = ID_W'(j);
         end
      end
   end
`endif

endmodule : irq_prio_sel

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge capture into pending bits, enable masking,
// source selection and a claim/complete handshake with the CPU.
// Build option IRQ_RR_EN: round-robin selection with a last-grant register;
// default build uses fixed priority.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int NUM_SRC = IRQ_NUM_SRC_DEF,
   parameter int ID_W    = $clog2(NUM_SRC)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_SRC-1:0] i_src_irq,
   input  logic               i_en_wr,
   input  logic [NUM_SRC-1:0] i_en_wdata,
   output logic [NUM_SRC-1:0] o_en_mask,
   output logic [NUM_SRC-1:0] o_pending,
   input  logic               i_cpu_stall,
   input  logic               i_claim,
   input  logic               i_complete,
   output logic               o_irq_out,
   output logic [ID_W-1:0]    o_claim_id,
   output logic               o_busy
);

   logic [NUM_SRC-1:0] r_src_q;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_en_mask;
   irq_state_t         r_state;
   logic [ID_W-1:0]    r_claim_id;
   logic               r_irq_out;
   logic               r_busy;

   logic [NUM_SRC-1:0] w_edge;
   logic [NUM_SRC-1:0] w_eligible;
   logic [NUM_SRC-1:0] w_clr;
   logic               w_sel_valid;
   logic [ID_W-1:0]    w_sel_id;
   irq_state_t         w_state_nxt;
   logic               w_claim_acc;

   assign w_edge     = i_src_irq & ~r_src_q;
   assign w_eligible = r_pending & r_en_mask;
   assign w_clr      = w_claim_acc ? (NUM_SRC'(1) << r_claim_id) : '0;

`ifdef IRQ_RR_EN
   logic [ID_W-1:0] r_last_grant;

   // Remember the most recently claimed source to rotate the search start
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last_grant <= ID_W'(NUM_SRC - 1);
      end else if (w_claim_acc) begin
         r_last_grant <= r_claim_id;
      end
   end

   irq_prio_sel #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_sel (
      .i_eligible   (w_eligible),
      .i_last_grant (r_last_grant),
      .o_valid      (w_sel_valid),
      .o_sel_id     (w_sel_id)
   );
`else
   irq_prio_sel #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_sel (
      .i_eligible (w_eligible),
      .o_valid    (w_sel_valid),
      .o_sel_id   (w_sel_id)
   );
`endif

   // Edge detect history, pending capture (set beats clear) and enable mask
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_src_q   <= '0;
         r_pending <= '0;
         r_en_mask <= '0;
      end else begin
         r_src_q   <= i_src_irq;
         r_pending <= (r_pending & ~w_clr) | w_edge;
         if (i_en_wr) begin
            r_en_mask <= i_en_wdata;
         end
      end
   end

   // Next-state logic; a request whose source lost eligibility is cancelled
   // before a claim is considered so a masked source is never claimed
   always_comb begin
      w_state_nxt = r_state;
      w_claim_acc = 1'b0;
      case (r_state)
         IRQ_IDLE: begin
            if (w_sel_valid) begin
               w_state_nxt = IRQ_REQ;
            end
         end
         IRQ_REQ: begin
            if (!w_eligible[r_claim_id]) begin
               w_state_nxt = IRQ_IDLE;
            end else if (i_claim && !i_cpu_stall) begin
               w_claim_acc = 1'b1;
               w_state_nxt = IRQ_SVC;
            end
         end
         IRQ_SVC: begin
            if (i_complete && !i_cpu_stall) begin
               w_state_nxt = IRQ_IDLE;
            end
         end
         default: begin
            w_state_nxt = IRQ_IDLE;
         end
      endcase
   end

   // State register, latched request ID and registered handshake outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= IRQ_IDLE;
         r_claim_id <= '0;
         r_irq_out  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_irq_out <= (w_state_nxt == IRQ_REQ);
         r_busy    <= (w_state_nxt == IRQ_SVC);
         if ((r_state == IRQ_IDLE) && w_sel_valid) begin
            r_claim_id <= w_sel_id;
         end
      end
   end

   assign o_en_mask  = r_en_mask;
   assign o_pending  = r_pending;
   assign o_irq_out  = r_irq_out;
   assign o_claim_id = r_claim_id;
   assign o_busy     = r_busy;

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl with hand-computed expectations.
// Honours IRQ_RR_EN for the simultaneous-source ordering check.
module tb_irq_ctrl;

   localparam int NumSrc = 4;
   localparam int IdW    = 2;

   logic              clk;
   logic              rst;
   logic [NumSrc-1:0] srcIrq;
   logic              enWr;
   logic [NumSrc-1:0] enWdata;
   logic [NumSrc-1:0] enMask;
   logic [NumSrc-1:0] pending;
   logic              cpuStall;
   logic              claim;
   logic              complete;
   logic              irqOut;
   logic [IdW-1:0]    claimId;
   logic              busy;

   int checkCount = 0;
   int errorCount = 0;

   irq_ctrl #(
      .NUM_SRC (NumSrc),
      .ID_W    (IdW)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_src_irq   (srcIrq),
      .i_en_wr     (enWr),
      .i_en_wdata  (enWdata),
      .o_en_mask   (enMask),
      .o_pending   (pending),
      .i_cpu_stall (cpuStall),
      .i_claim     (claim),
      .i_complete  (complete),
      .o_irq_out   (irqOut),
      .o_claim_id  (claimId),
      .o_busy      (busy)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle pulse on the given source lines
   task automatic applyStimulus(input logic [NumSrc-1:0] srcs);
      srcIrq = srcs;
      tick();
      srcIrq = '0;
   endtask

   task automatic writeMask(input logic [NumSrc-1:0] mask);
      enWr    = 1'b1;
      enWdata = mask;
      tick();
      enWr    = 1'b0;
   endtask

   task automatic doClaim();
      claim = 1'b1;
      tick();
      claim = 1'b0;
   endtask

   task automatic doComplete();
      complete = 1'b1;
      tick();
      complete = 1'b0;
   endtask

   logic [IdW-1:0]    expFirst;
   logic [IdW-1:0]    expSecond;
   logic [NumSrc-1:0] expLeft;

   initial begin
`ifdef IRQ_RR_EN
      expFirst  = 2'd3;
      expSecond = 2'd1;
      expLeft   = 4'b0010;
`else
      expFirst  = 2'd1;
      expSecond = 2'd3;
      expLeft   = 4'b1000;
`endif
      rst      = 1'b1;
      srcIrq   = '0;
      enWr     = 1'b0;
      enWdata  = '0;
      cpuStall = 1'b0;
      claim    = 1'b0;
      complete = 1'b0;
      #1;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("rst_irq", irqOut, 0);
      checkOutput("rst_id", claimId, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_pend", pending, 0);
      checkOutput("rst_mask", enMask, 0);

      // Claim in IDLE is ignored
      doClaim();
      checkOutput("idle_claim_busy", busy, 0);

      // Basic flow on source 0
      writeMask(4'b0011);
      checkOutput("mask_0011", enMask, 4'b0011);
      applyStimulus(4'b0001);
      checkOutput("src0_pend", pending, 4'b0001);
      checkOutput("src0_irq_early", irqOut, 0);
      tick();
      checkOutput("src0_irq", irqOut, 1);
      checkOutput("src0_id", claimId, 0);
      doClaim();
      checkOutput("claim0_irq", irqOut, 0);
      checkOutput("claim0_pend", pending, 0);
      checkOutput("claim0_busy", busy, 1);
      doComplete();
      checkOutput("cmpl0_busy", busy, 0);

      // Masked source fires once enabled
      applyStimulus(4'b0100);
      tick();
      checkOutput("src2_pend", pending, 4'b0100);
      checkOutput("src2_masked_irq", irqOut, 0);
      writeMask(4'b0111);
      tick();
      checkOutput("src2_irq", irqOut, 1);
      checkOutput("src2_id", claimId, 2);
      doClaim();
      doComplete();

      // Sources 1 and 3 together
      writeMask(4'b1111);
      applyStimulus(4'b1010);
      tick();
      checkOutput("pair_first_id", claimId, expFirst);
      doClaim();
      checkOutput("pair_left_pend", pending, expLeft);
      doComplete();
      checkOutput("pair_gap_irq", irqOut, 0);
      tick();
      checkOutput("pair_second_irq", irqOut, 1);
      checkOutput("pair_second_id", claimId, expSecond);

      // Claim held off by stall
      cpuStall = 1'b1;
      claim    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("stall_irq", irqOut, 1);
         checkOutput("stall_busy", busy, 0);
      end
      cpuStall = 1'b0;
      tick();
      claim = 1'b0;
      checkOutput("unstall_busy", busy, 1);
      checkOutput("unstall_irq", irqOut, 0);
      cpuStall = 1'b1;
      complete = 1'b1;
      tick();
      checkOutput("stall_cmpl_busy", busy, 1);
      cpuStall = 1'b0;
      tick();
      complete = 1'b0;
      checkOutput("unstall_cmpl_busy", busy, 0);

      // Spurious cancel by mask write
      applyStimulus(4'b0001);
      tick();
      checkOutput("cancel_req_irq", irqOut, 1);
      writeMask(4'b0000);
      tick();
      checkOutput("cancel_irq", irqOut, 0);
      checkOutput("cancel_pend", pending, 4'b0001);
      writeMask(4'b0001);
      tick();
      checkOutput("reenable_irq", irqOut, 1);
      checkOutput("reenable_id", claimId, 0);

      // Edge and claim of the same source in one cycle
      srcIrq = 4'b0001;
      claim  = 1'b1;
      tick();
      srcIrq = '0;
      claim  = 1'b0;
      checkOutput("same_pend", pending, 4'b0001);
      checkOutput("same_busy", busy, 1);
      doComplete();
      tick();
      checkOutput("same_refire_irq", irqOut, 1);
      checkOutput("same_refire_id", claimId, 0);
      doClaim();
      applyStimulus(4'b0010);
      checkOutput("svc_accum_pend", pending, 4'b0010);

      // Reset during service
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("svc_rst_busy", busy, 0);
      checkOutput("svc_rst_irq", irqOut, 0);
      checkOutput("svc_rst_pend", pending, 0);
      checkOutput("svc_rst_mask", enMask, 0);
      checkOutput("svc_rst_id", claimId, 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule : tb_irq_ctrl

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller between the peripheral interrupt lines (DMA done, WDT timeout, spare sources) and the CPU CSR unit's single external-interrupt input. It captures rising edges per source into pending bits, masks them with a software-written enable register, and selects one eligible source. It then drives a single request line with a stable source ID and follows a claim/complete handshake tied to trap entry and `mret`. Only one interrupt is in service at a time; there is no nesting.

## Interface
- `NUM_SRC`, default 4: number of interrupt sources, 2..16.
- `ID_W`, default `$clog2(NUM_SRC)`: width of source ID.
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `src_irq` in NUM_SRC: raw source lines, synchronous to `clk`, edge-sensitive.
- `en_wr` in 1: enable-register write strobe.
- `en_wdata` in NUM_SRC: new enable mask.
- `en_mask` out NUM_SRC: current enable mask.
- `pending` out NUM_SRC: current pending bits, for debug and CSR read.
- `cpu_stall` in 1: `im_stall | dm_stall`. While high, `claim` and `complete` are ignored.
- `claim` in 1: CPU has taken the trap.
- `complete` in 1: CPU executed `mret`.
- `irq_out` out 1: request to the CSR external-interrupt input, registered.
- `claim_id` out ID_W: ID of the requested or in-service source, registered.
- `busy` out 1: a source is in service.

## Operation
- Edge capture:
  - `src_q` holds last-cycle `src_irq`.
  - An edge is `src_irq & ~src_q`; an edge sets the corresponding `pending[i]`.
  - `pending[i]` clears only on an accepted claim of ID `i`.
  - If an edge of `i` and a claim of `i` occur in the same cycle, the set wins and the new event is kept.
- Enable:
  - `en_wr` loads `en_mask` on the next edge.
  - Masking never clears pending bits; a masked pending bit fires once re-enabled.
- Eligible set: `pending & en_mask`. The selector picks one index (see Configuration).
- FSM (`IRQ_IDLE`, `IRQ_REQ`, `IRQ_SVC`):
  - IDLE: if the eligible set is non-zero → REQ, latching the selected index into `claim_id`.
  - REQ: `irq_out`=1.
    - `claim & ~cpu_stall` → SVC; clears `pending[claim_id]` and updates `last_grant`.
    - If the eligible bit for `claim_id` drops (mask write) before the claim → IDLE and `irq_out` falls. This is a spurious-cancel.
    - `claim_id` never changes while in REQ, even if a higher-priority source arrives.
  - SVC: `irq_out`=0 and `busy`=1.
    - `complete & ~cpu_stall` → IDLE.
    - New edges only accumulate in `pending`.
- Ignored inputs: `claim` in IDLE or SVC; `complete` in IDLE or REQ.
- Pending arbitration restarts in IDLE on the cycle after `complete`.

## Timing
- Reset values:
  - `pending`=0, `en_mask`=0, `src_q`=0
  - state IDLE, `irq_out`=0, `claim_id`=0, `busy`=0
  - `last_grant`=NUM_SRC-1
- Reset mid-service returns to IDLE and discards all pending events.
- Latency:
  - Source rising at edge k sets `pending` visible after k.
  - The FSM enters REQ at edge k+1.
  - `irq_out`=1 from k+1, i.e. 2 cycles from a registered source edge.
- Claim accepted at edge m: `irq_out`=0 and `busy`=1 after m.
- Complete accepted at edge n:
  - State is IDLE after n.
  - The next REQ is no earlier than n+1, giving back-to-back service with a 1-cycle idle gap.
- Simultaneous `en_wr` and edge: both take effect at the same edge.
- `claim` and `complete` asserted together: only the one matching the current state is honoured.

## Configuration
- `IRQ_RR_EN` defined: round-robin selection.
  - Search starts at `(last_grant+1) mod NUM_SRC` and wraps.
  - `last_grant` updates on each accepted claim.
- `IRQ_RR_EN` undefined: fixed priority, lowest index wins.
  - `last_grant` is neither implemented nor used.

## Structure
- Package `irq_pkg`:
  - `irq_state_t` enum {IRQ_IDLE, IRQ_REQ, IRQ_SVC}
  - `IRQ_NUM_SRC_DEF`=4
  - source index constants `IRQ_SRC_DMA`=0, `IRQ_SRC_WDT`=1
- Sub-module `irq_prio_sel`: combinational, inputs eligible vector and `last_grant`; outputs `valid` and `sel_id`. It holds both selection variants under `IRQ_RR_EN`.
- FSM, pending and enable registers stay in `irq_ctrl`.

## Test plan
- Reset, enable mask 4'b0011, pulse `src_irq[0]` → `irq_out`=1 two cycles later with `claim_id`=0. `claim` → `irq_out`=0, `pending`=0, `busy`=1. `complete` → `busy`=0.
- `src_irq[2]` pulse with mask 4'b0011 → `pending`=4'b0100 and no `irq_out`. Write mask 4'b0111 → `irq_out` with `claim_id`=2.
- Sources 1 and 3 in the same cycle, fixed priority → service 1, then 3 after complete. With `IRQ_RR_EN` and `last_grant`=1 → service 3 first, then 1.
- `claim` held with `cpu_stall`=1 for 3 cycles → state stays REQ and `irq_out` stays 1. Drop the stall → claim accepted.
- In REQ for ID 0, write mask 0 → `irq_out` falls the next cycle and `pending[0]` is still 1.
- Edge on `src_irq[0]` in the same cycle as its claim → after `complete`, a second request fires with `claim_id`=0. Asserting `rst` in SVC → all outputs return to reset values.
